c17_resp_misr: RTL and testbench

- Response compactor directly downstream of the c17 NAND2 netlist.
- Consumes one c17 response pair (N22, N23) per accepted pattern and folds it into a multiple-input signature register (MISR).
- Counts patterns, stops after a programmed number of patterns, and compares the final signature against a golden value.
- Gives pass/fail for gate-sized netlist variants without storing full response traces.

---
 rtl/c17_resp_misr.sv | 155 +++++++++++++++
 tb/tb_c17_resp_misr.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c17_resp_misr.sv
// c17 response compactor: folds (N22,N23) pairs into a MISR.
// Counts patterns and checks the final signature against GOLDEN.
//
// Ports:
//   CK, RST            clock (rising edge), async active-high reset
//   start              begin a run (honoured in IDLE and DONE)
//   in_valid, N22, N23 response pair from the c17 netlist
//   resp_mask          per-bit injection mask (C17_MISR_XMASK_EN only)
//   in_ready           response accepted this cycle when in_valid=1
//   busy, done, pass   run status; pass is only meaningful with done
//   signature, pat_cnt current MISR and accepted-pattern count
//
// Optional feature macro: C17_MISR_XMASK_EN adds resp_mask after N23.
module c17_resp_misr #(
  parameter int                MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY   = 16'h1021,
  parameter int                NPAT   = 32,
  parameter int                CNT_W  = 8,
  parameter logic [MISR_W-1:0] GOLDEN = 16'h0000
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  input  logic              N22,
  input  logic              N23,
`ifdef C17_MISR_XMASK_EN
  input  logic [1:0]        resp_mask,
`endif
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [CNT_W-1:0]  pat_cnt
);

  if (MISR_W < 2) begin : g_bad_w
    $error("c17_resp_misr: MISR_W must be >= 2");
  end

  if (NPAT < 1 || NPAT > (2**CNT_W) - 1) begin : g_bad_npat
    $error("c17_resp_misr: NPAT out of counter range");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NPAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              clr;
  logic              acc;
  logic              last;
  logic              i22;
  logic              i23;
  logic [MISR_W-1:0] fb;
  logic [MISR_W-1:0] inj;
  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_nx;
  logic [CNT_W-1:0]  cnt_q;
  logic              pass_q;

  assign acc  = (state_q == RUN) && in_valid;
  assign last = (cnt_q == LAST);

`ifdef C17_MISR_XMASK_EN
  assign i22 = N22 & ~resp_mask[0];
  assign i23 = N23 & ~resp_mask[1];
`else
  assign i22 = N22;
  assign i23 = N23;
`endif

  assign fb  = sig_q[MISR_W-1] ? POLY : '0;
  assign inj = {{(MISR_W-2){1'b0}}, i23, i22};

  assign sig_nx = {sig_q[MISR_W-2:0], 1'b0}
                ^ fb ^ inj;

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (acc && last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Data only moves on an accept, so X on N22/N23
  // outside an accept never reaches the register.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      sig_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      sig_q <= '0;
      cnt_q <= '0;
    end else if (acc) begin
      sig_q <= sig_nx;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Verdict is taken from the value being written on
  // the final accept, so it is ready as DONE begins.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      pass_q <= 1'b0;
    end else if (acc && last) begin
      pass_q <= (sig_nx == GOLDEN);
    end else if (state_d != DONE) begin
      pass_q <= 1'b0;
    end
  end

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q && (state_q == DONE);
  assign signature = sig_q;
  assign pat_cnt   = cnt_q;

endmodule

// File: tb/tb_c17_resp_misr.sv
// Bench for c17_resp_misr: three instances with
// different run lengths against a polynomial model.
module tb_c17_resp_misr;

  localparam logic [15:0] POLY_T = 16'h1021;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       iv = 1'b0;
  logic       n22 = 1'b0;
  logic       n23 = 1'b0;
  logic [1:0] msk = 2'b00;
  logic       st_a = 1'b0;
  logic       st_b = 1'b0;
  logic       st_c = 1'b0;

  logic        rdy_a, busy_a, done_a, pass_a;
  logic        rdy_b, busy_b, done_b, pass_b;
  logic        rdy_c, busy_c, done_c, pass_c;
  logic [15:0] sig_a, sig_b, sig_c;
  logic [7:0]  cnt_a, cnt_b, cnt_c;

  int nrun = 0;
  int nfail = 0;

  always #5 ck = ~ck;

  c17_resp_misr #(.NPAT(17), .GOLDEN(16'h0000)) ua (
    .CK(ck), .RST(rst), .start(st_a),
    .in_valid(iv), .N22(n22), .N23(n23),
`ifdef C17_MISR_XMASK_EN
    .resp_mask(msk),
`endif
    .in_ready(rdy_a), .busy(busy_a),
    .done(done_a), .pass(pass_a),
    .signature(sig_a), .pat_cnt(cnt_a)
  );

  c17_resp_misr #(.NPAT(1), .GOLDEN(16'h0001)) ub (
    .CK(ck), .RST(rst), .start(st_b),
    .in_valid(iv), .N22(n22), .N23(n23),
`ifdef C17_MISR_XMASK_EN
    .resp_mask(msk),
`endif
    .in_ready(rdy_b), .busy(busy_b),
    .done(done_b), .pass(pass_b),
    .signature(sig_b), .pat_cnt(cnt_b)
  );

  c17_resp_misr #(.NPAT(3), .GOLDEN(16'h0009)) uc (
    .CK(ck), .RST(rst), .start(st_c),
    .in_valid(iv), .N22(n22), .N23(n23),
`ifdef C17_MISR_XMASK_EN
    .resp_mask(msk),
`endif
    .in_ready(rdy_c), .busy(busy_c),
    .done(done_c), .pass(pass_c),
    .signature(sig_c), .pat_cnt(cnt_c)
  );

  // Signature as a GF(2) polynomial: multiply by x,
  // reduce modulo x^16 + POLY, then add the response.
  function automatic logic [15:0] mstep(
    input logic [15:0] s, input bit a, input bit b);
    int t;
    t = 2 * int'(s);
    if (t > 65535) t = (t - 65536) ^ int'(POLY_T);
    t = t ^ (2 * int'(b) + int'(a));
    return t[15:0];
  endfunction

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic acc(input logic a, input logic b);
    iv = 1'b1;
    n22 = a;
    n23 = b;
    tick();
    iv = 1'b0;
    n22 = 1'bx;
    n23 = 1'bx;
  endtask

  task automatic go(input int sel);
    case (sel)
      0: st_a = 1'b1;
      1: st_b = 1'b1;
      default: st_c = 1'b1;
    endcase
    tick();
    st_a = 1'b0;
    st_b = 1'b0;
    st_c = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    nrun++;
    if ({rdy_a, busy_a, done_a, pass_a, sig_a, cnt_a}
        !== 28'h0) begin
      nfail++;
      $display("FAIL reset_a got %b %h %h exp 0000 0 0",
        {rdy_a, busy_a, done_a, pass_a}, sig_a, cnt_a);
    end
    nrun++;
    if ({sig_b, sig_c, done_b, done_c} !== 34'h0) begin
      nfail++;
      $display("FAIL reset_bc got %h %h %b%b exp 0 0 00",
        sig_b, sig_c, done_b, done_c);
    end
    @(negedge ck);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_npat1();
    go(1);
    nrun++;
    if ({rdy_b, busy_b, done_b} !== 3'b110) begin
      nfail++;
      $display("FAIL npat1_run got %b exp 110",
        {rdy_b, busy_b, done_b});
    end
    acc(1'b1, 1'b0);
    nrun++;
    if (sig_b !== 16'h0001 || cnt_b !== 8'd1) begin
      nfail++;
      $display("FAIL npat1_sig got %h/%0d exp 0001/1",
        sig_b, cnt_b);
    end
    nrun++;
    if ({rdy_b, busy_b, done_b, pass_b} !== 4'b0011) begin
      nfail++;
      $display("FAIL npat1_done got %b exp 0011",
        {rdy_b, busy_b, done_b, pass_b});
    end
  endtask

  task automatic test_npat3();
    logic [15:0] e;
    logic [15:0] tbl [3];
    tbl = '{16'h0003, 16'h0005, 16'h0009};
    e = 16'h0;
    go(2);
    for (int i = 0; i < 3; i++) begin
      acc(1'b1, 1'b1);
      e = mstep(e, 1'b1, 1'b1);
      nrun++;
      if (sig_c !== e || sig_c !== tbl[i]) begin
        nfail++;
        $display("FAIL npat3_sig%0d got %h exp %h",
          i, sig_c, tbl[i]);
      end
      nrun++;
      if (done_c !== (i == 2)) begin
        nfail++;
        $display("FAIL npat3_done%0d got %b exp %b",
          i, done_c, (i == 2));
      end
    end
    nrun++;
    if (pass_c !== 1'b1) begin
      nfail++;
      $display("FAIL npat3_pass got %b exp 1", pass_c);
    end
    iv = 1'b1;
    n22 = 1'b1;
    n23 = 1'b0;
    tick();
    tick();
    iv = 1'b0;
    nrun++;
    if (sig_c !== 16'h0009 || cnt_c !== 8'd3
        || done_c !== 1'b1) begin
      nfail++;
      $display("FAIL done_hold got %h/%0d/%b exp 0009/3/1",
        sig_c, cnt_c, done_c);
    end
  endtask

  task automatic test_gaps();
    go(2);
    nrun++;
    if ({done_c, pass_c, busy_c} !== 3'b001
        || sig_c !== 16'h0 || cnt_c !== 8'd0) begin
      nfail++;
      $display("FAIL restart got %b %h %0d exp 001 0000 0",
        {done_c, pass_c, busy_c}, sig_c, cnt_c);
    end
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < 2; g++) begin
        iv = 1'b0;
        n22 = 1'bx;
        n23 = 1'bx;
        st_c = (i == 1 && g == 0);
        tick();
        st_c = 1'b0;
      end
      nrun++;
      if (cnt_c !== 8'(i) || busy_c !== 1'b1) begin
        nfail++;
        $display("FAIL gap_hold%0d got %0d/%b exp %0d/1",
          i, cnt_c, busy_c, i);
      end
      acc(1'b1, 1'b1);
    end
    nrun++;
    if (sig_c !== 16'h0009 || done_c !== 1'b1
        || pass_c !== 1'b1) begin
      nfail++;
      $display("FAIL gap_final got %h/%b/%b exp 0009/1/1",
        sig_c, done_c, pass_c);
    end
  endtask

  task automatic test_feedback();
    go(0);
    acc(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) acc(1'b0, 1'b0);
    nrun++;
    if (sig_a !== 16'h8000 || cnt_a !== 8'd16
        || done_a !== 1'b0) begin
      nfail++;
      $display("FAIL fb16 got %h/%0d/%b exp 8000/16/0",
        sig_a, cnt_a, done_a);
    end
    acc(1'b0, 1'b0);
    nrun++;
    if (sig_a !== 16'h1021 || cnt_a !== 8'd17
        || done_a !== 1'b1 || pass_a !== 1'b0) begin
      nfail++;
      $display("FAIL fb17 got %h/%0d/%b%b exp 1021/17/10",
        sig_a, cnt_a, done_a, pass_a);
    end
  endtask

  task automatic test_random();
    logic [2:0] q [$];
    logic [15:0] e;
    bit a, b;
    bit [1:0] m;
    for (int r = 0; r < 4; r++) begin
      q.delete();
      go(0);
      for (int k = 0; k < 17; k++) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          iv = 1'b0;
          n22 = 1'($urandom);
          n23 = 1'($urandom);
          tick();
        end
        a = 1'($urandom);
        b = 1'($urandom);
        m = 2'b00;
`ifdef C17_MISR_XMASK_EN
        m = 2'($urandom);
`endif
        q.push_back({m[1] ? 1'b0 : b, m[0] ? 1'b0 : a, 1'b0});
        msk = m;
        acc(a, b);
        msk = 2'b00;
        nrun++;
        if (cnt_a !== 8'(k + 1)) begin
          nfail++;
          $display("FAIL rnd%0d_cnt got %0d exp %0d",
            r, cnt_a, k + 1);
        end
      end
      e = 16'h0;
      foreach (q[j]) e = mstep(e, q[j][1], q[j][2]);
      nrun++;
      if (sig_a !== e || done_a !== 1'b1
          || pass_a !== (e == 16'h0000)) begin
        nfail++;
        $display("FAIL rnd%0d_sig got %h/%b%b exp %h/1%b",
          r, sig_a, done_a, pass_a, e, (e == 16'h0));
      end
    end
  endtask

  task automatic test_reset_mid();
    go(0);
    for (int i = 0; i < 5; i++) acc(1'($urandom), 1'b1);
    nrun++;
    if (cnt_a !== 8'd5 || busy_a !== 1'b1) begin
      nfail++;
      $display("FAIL mid_pre got %0d/%b exp 5/1",
        cnt_a, busy_a);
    end
    #2;
    rst = 1'b1;
    #1;
    nrun++;
    if ({rdy_a, busy_a, done_a, pass_a, sig_a, cnt_a}
        !== 28'h0) begin
      nfail++;
      $display("FAIL mid_rst got %b %h %0d exp 0000 0000 0",
        {rdy_a, busy_a, done_a, pass_a}, sig_a, cnt_a);
    end
    @(negedge ck);
    rst = 1'b0;
    go(0);
    acc(1'b0, 1'b1);
    nrun++;
    if (sig_a !== 16'h0002 || cnt_a !== 8'd1) begin
      nfail++;
      $display("FAIL mid_clean got %h/%0d exp 0002/1",
        sig_a, cnt_a);
    end
  endtask

  task automatic test_mask();
    logic [15:0] e;
`ifdef C17_MISR_XMASK_EN
    e = 16'h0002;
`else
    e = 16'h0003;
`endif
    go(1);
    msk = 2'b01;
    acc(1'b1, 1'b1);
    msk = 2'b00;
    nrun++;
    if (sig_b !== e || done_b !== 1'b1
        || pass_b !== 1'b0) begin
      nfail++;
      $display("FAIL mask got %h/%b%b exp %h/10",
        sig_b, done_b, pass_b, e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_npat1();
    test_npat3();
    test_gaps();
    test_feedback();
    test_random();
    test_reset_mid();
    test_mask();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
